decompose_r1_ctrl: RTL and testbench
====================================

Name: decompose_r1_ctrl

Overview:
- Sequencer that streams polynomial coefficients from the coefficient memory through four parallel highbits (r1) look-up datapath lanes.
- Packs the resulting 4-bit r1 values into 16-bit words and writes them to the w1 buffer.
- Counts corner-case coefficients over the run.
- Sits between the top-level ML-DSA control and the decompose datapath; one start pulse processes NUM_POLY whole polynomials.

Parameters:
- REG_SIZE, 23: coefficient width per lane.
- NUM_POLY, 8: polynomials per run.
- WORDS_PER_POLY, 64: memory words per polynomial (4 coefficients per word, 256 coefficients per polynomial).
- ADDR_W, 15: memory address width.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- zeroize  in  1  synchronous clear of all state, priority over all other inputs.
- start_i  in  1  one-cycle start pulse.
- src_base_i  in  ADDR_W  first source word address; sampled on accepted start.
- dst_base_i  in  ADDR_W  first w1 word address; sampled on accepted start.
- mem_rd_en_o  out  1  coefficient memory read strobe.
- mem_rd_addr_o  out  ADDR_W  read address.
- mem_rd_data_i  in  4*REG_SIZE  read data, valid the cycle after mem_rd_en_o; lane 0 in the LSBs.
- dp_valid_o  out  1  dp_coeff_o holds valid coefficients.
- dp_coeff_o  out  4*REG_SIZE  registered coefficients to the four r1 lanes.
- dp_r1_i  in  16  four 4-bit r1 results, combinational from dp_coeff_o; lane 0 in bits 3:0.
- dp_corner_i  in  4  per-lane corner flags, combinational.
- w1_wr_en_o  out  1  w1 write strobe.
- w1_wr_addr_o  out  ADDR_W  w1 write address.
- w1_wr_data_o  out  16  packed r1 word.
- corner_cnt_o  out  11  corner coefficients counted in the current or last run; saturates at 2047.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (rst_b low) or zeroize: every output and internal register goes to 0 and the FSM goes to IDLE. Zeroize mid-run aborts the run with no done_o pulse; writes still in the pipe are discarded.
- States:
  - IDLE: start_i latches the bases, clears corner_cnt_o, sets busy_o, goes to RUN. start_i is ignored in every state except IDLE.
  - RUN: one read per cycle. mem_rd_en_o=1 and mem_rd_addr_o = src_base + rd_cnt. rd_cnt runs 0 to TOTAL-1, where TOTAL = NUM_POLY*WORDS_PER_POLY. After the read issued with rd_cnt=TOTAL-1, go to FLUSH.
  - FLUSH: no reads. Wait until the pipeline valid bits are all 0, then go to DONE.
  - DONE: done_o=1 for one cycle, busy_o drops to 0 in the same cycle, return to IDLE.
- Pipeline, read issued in cycle N:
  - N+1: mem_rd_data_i is valid and is registered into dp_coeff_o.
  - N+2: dp_valid_o=1 and dp_r1_i/dp_corner_i are sampled.
  - N+3: w1_wr_en_o=1, w1_wr_data_o = dp_r1_i as sampled, w1_wr_addr_o = dst_base + wr_cnt.
  - Fixed latency is 3 cycles read-to-write. There is no stall, so throughput is one word per cycle.
- wr_cnt increments on each write. Address additions wrap modulo 2^ADDR_W.
- corner_cnt_o adds popcount(dp_corner_i) on every dp_valid_o cycle and saturates at 2047. It holds its value after done until the next accepted start.
- dp_coeff_o holds its last value when dp_valid_o=0. Downstream logic only uses it when dp_valid_o=1.
- Total run length: TOTAL + 4 cycles from the start cycle to the done_o pulse (RUN TOTAL, FLUSH 3, DONE 1). busy_o is high for the same span, excluding the start cycle.
- A start_i asserted in the same cycle as done_o is ignored. A start_i in the following cycle is accepted.

Test Plan:
- Reset then idle: all outputs 0. A start with src_base=0x100 and dst_base=0x40 gives the first mem_rd_addr_o=0x100 in the next cycle, and 512 consecutive reads end at 0x2FF.
- Datapath echo model with r1 lanes 0x1,0x2,0x3,0xF: w1_wr_data_o=0xF321 is written exactly 3 cycles after the matching read. Writes go to 0x40 through 0x23F, 512 of them with no gaps.
- Corner injection: dp_corner_i=4'b1011 on 3 valid words and 0 elsewhere gives corner_cnt_o=9 at done_o.
- Saturation: dp_corner_i=4'hF on every word (2048 events) gives corner_cnt_o=2047.
- start_i pulsed mid-RUN and again in the done_o cycle: both ignored. A start one cycle after done_o is accepted and corner_cnt_o clears to 0.
- zeroize asserted at rd_cnt=100: the next cycle shows all outputs 0 and state IDLE, with no further writes and no done_o. Repeat with rst_b pulsed low mid-FLUSH: same result.

Source files
------------

// File: rtl/decompose_r1_ctrl.sv
// decompose_r1_ctrl: streams coefficient words from memory through four r1
// look-up lanes, packs the 4-bit results into 16-bit w1 words, and counts
// corner-case coefficients over a run of NUM_POLY polynomials.
module decompose_r1_ctrl #(
  parameter int REG_SIZE       = 23,
  parameter int NUM_POLY       = 8,
  parameter int WORDS_PER_POLY = 64,
  parameter int ADDR_W         = 15
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    zeroize,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       src_base_i,
  input  logic [ADDR_W-1:0]       dst_base_i,
  output logic                    mem_rd_en_o,
  output logic [ADDR_W-1:0]       mem_rd_addr_o,
  input  logic [4*REG_SIZE-1:0]   mem_rd_data_i,
  output logic                    dp_valid_o,
  output logic [4*REG_SIZE-1:0]   dp_coeff_o,
  input  logic [15:0]             dp_r1_i,
  input  logic [3:0]              dp_corner_i,
  output logic                    w1_wr_en_o,
  output logic [ADDR_W-1:0]       w1_wr_addr_o,
  output logic [15:0]             w1_wr_data_o,
  output logic [10:0]             corner_cnt_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int TOTAL = NUM_POLY * WORDS_PER_POLY;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  src_base_r;
  logic [ADDR_W-1:0]  dst_base_r;
  logic [CNT_W-1:0]   rd_cnt_r;
  logic [CNT_W-1:0]   wr_cnt_r;
  logic [CNT_W-1:0]   rd_cnt_nxt_s;
  logic               rd_vld_r;
  logic               start_acc_s;
  logic [11:0]        corner_sum_s;
  logic [10:0]        corner_nxt_s;

  // Number of set corner flags across the four lanes.
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  assign start_acc_s = start_i && (state_r == ST_IDLE);

  // Next read index and saturating corner-count update.
  always_comb begin
    rd_cnt_nxt_s = rd_cnt_r + CNT_ONE;
    corner_sum_s = {1'b0, corner_cnt_o} + {9'd0, popcount4(dp_corner_i)};
    if (corner_sum_s > 12'd2047) begin
      corner_nxt_s = 11'd2047;
    end else begin
      corner_nxt_s = corner_sum_s[10:0];
    end
  end

  // Run sequencer: issues one read per cycle, then drains the pipe and pulses done.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r       <= ST_IDLE;
      src_base_r    <= {ADDR_W{1'b0}};
      dst_base_r    <= {ADDR_W{1'b0}};
      rd_cnt_r      <= {CNT_W{1'b0}};
      mem_rd_en_o   <= 1'b0;
      mem_rd_addr_o <= {ADDR_W{1'b0}};
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else if (zeroize) begin
      state_r       <= ST_IDLE;
      src_base_r    <= {ADDR_W{1'b0}};
      dst_base_r    <= {ADDR_W{1'b0}};
      rd_cnt_r      <= {CNT_W{1'b0}};
      mem_rd_en_o   <= 1'b0;
      mem_rd_addr_o <= {ADDR_W{1'b0}};
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_acc_s) begin
            src_base_r    <= src_base_i;
            dst_base_r    <= dst_base_i;
            rd_cnt_r      <= {CNT_W{1'b0}};
            mem_rd_en_o   <= 1'b1;
            mem_rd_addr_o <= src_base_i;
            busy_o        <= 1'b1;
            state_r       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_cnt_r == LAST_RD) begin
            mem_rd_en_o <= 1'b0;
            state_r     <= ST_FLUSH;
          end else begin
            rd_cnt_r      <= rd_cnt_nxt_s;
            mem_rd_addr_o <= src_base_r + ADDR_W'(rd_cnt_nxt_s);
          end
        end
        ST_FLUSH: begin
          // The final write is on the outputs this cycle; nothing remains behind it.
          if (!rd_vld_r && !dp_valid_o) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Fixed three-stage pipe: read data -> lane coefficients -> packed w1 write.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_vld_r     <= 1'b0;
      dp_valid_o   <= 1'b0;
      dp_coeff_o   <= {(4*REG_SIZE){1'b0}};
      w1_wr_en_o   <= 1'b0;
      w1_wr_addr_o <= {ADDR_W{1'b0}};
      w1_wr_data_o <= 16'd0;
      wr_cnt_r     <= {CNT_W{1'b0}};
      corner_cnt_o <= 11'd0;
    end else if (zeroize) begin
      rd_vld_r     <= 1'b0;
      dp_valid_o   <= 1'b0;
      dp_coeff_o   <= {(4*REG_SIZE){1'b0}};
      w1_wr_en_o   <= 1'b0;
      w1_wr_addr_o <= {ADDR_W{1'b0}};
      w1_wr_data_o <= 16'd0;
      wr_cnt_r     <= {CNT_W{1'b0}};
      corner_cnt_o <= 11'd0;
    end else begin
      rd_vld_r   <= mem_rd_en_o;
      dp_valid_o <= rd_vld_r;
      w1_wr_en_o <= dp_valid_o;
      if (rd_vld_r) begin
        dp_coeff_o <= mem_rd_data_i;
      end
      if (start_acc_s) begin
        wr_cnt_r     <= {CNT_W{1'b0}};
        corner_cnt_o <= 11'd0;
      end else if (dp_valid_o) begin
        w1_wr_data_o <= dp_r1_i;
        w1_wr_addr_o <= dst_base_r + ADDR_W'(wr_cnt_r);
        wr_cnt_r     <= wr_cnt_r + CNT_ONE;
        corner_cnt_o <= corner_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_decompose_r1_ctrl.sv
// Self-checking bench for decompose_r1_ctrl: memory and r1-lane models,
// scoreboard of expected w1 writes, and per-scenario test tasks.
module tb_decompose_r1_ctrl;

  localparam int TOTAL = 512;

  logic         clk;
  logic         rst_b;
  logic         zeroize;
  logic         start_i;
  logic [14:0]  src_base_i;
  logic [14:0]  dst_base_i;
  logic         mem_rd_en_o;
  logic [14:0]  mem_rd_addr_o;
  logic [91:0]  mem_rd_data_i;
  logic         dp_valid_o;
  logic [91:0]  dp_coeff_o;
  logic [15:0]  dp_r1_i;
  logic [3:0]   dp_corner_i;
  logic         w1_wr_en_o;
  logic [14:0]  w1_wr_addr_o;
  logic [15:0]  w1_wr_data_o;
  logic [10:0]  corner_cnt_o;
  logic         busy_o;
  logic         done_o;

  int checks;
  int failures;

  int          data_mode;
  int          corner_mode;
  logic [14:0] run_src;
  logic [14:0] last_rd_addr;
  logic [14:0] last_wr_addr;
  logic [15:0] last_wr_data;
  logic [10:0] done_corner;
  bit          done_seen;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [153:0] all_out_s;
  assign all_out_s = {mem_rd_en_o, mem_rd_addr_o, dp_valid_o, dp_coeff_o, w1_wr_en_o,
                      w1_wr_addr_o, w1_wr_data_o, corner_cnt_o, busy_o, done_o};

  decompose_r1_ctrl dut (
    .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .start_i(start_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .dp_valid_o(dp_valid_o), .dp_coeff_o(dp_coeff_o), .dp_r1_i(dp_r1_i), .dp_corner_i(dp_corner_i),
    .w1_wr_en_o(w1_wr_en_o), .w1_wr_addr_o(w1_wr_addr_o), .w1_wr_data_o(w1_wr_data_o),
    .corner_cnt_o(corner_cnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient word for an address: lane = {addr, lane idx, corner flag, r1 nibble}.
  function automatic logic [91:0] mem_word(input logic [14:0] a);
    logic [91:0] w;
    logic [3:0]  nib;
    logic [3:0]  cf;
    logic [15:0] fixed_v;
    fixed_v = 16'hF321;
    cf = 4'b0000;
    if (corner_mode == 1 && (a == run_src + 15'd5 || a == run_src + 15'd200 || a == run_src + 15'd511))
      cf = 4'b1011;
    else if (corner_mode == 2)
      cf = 4'b1111;
    w = 92'd0;
    for (int k = 0; k < 4; k++) begin
      if (data_mode == 1) nib = fixed_v[k*4 +: 4];
      else nib = a[3:0] + a[7:4] + 4'(k);
      w[k*23 +: 23] = {a, 3'(k), cf[k], nib};
    end
    return w;
  endfunction

  function automatic logic [15:0] r1_of(input logic [91:0] w);
    return {w[69 +: 4], w[46 +: 4], w[23 +: 4], w[0 +: 4]};
  endfunction

  function automatic int corner_pop(input logic [91:0] w);
    return int'(w[4]) + int'(w[27]) + int'(w[50]) + int'(w[73]);
  endfunction

  // Coefficient memory: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem_word(mem_rd_addr_o);
  end

  // r1 lanes: combinational echo of each lane's low nibble and corner bit.
  assign dp_r1_i     = {dp_coeff_o[69 +: 4], dp_coeff_o[46 +: 4], dp_coeff_o[23 +: 4], dp_coeff_o[0 +: 4]};
  assign dp_corner_i = {dp_coeff_o[73], dp_coeff_o[50], dp_coeff_o[27], dp_coeff_o[4]};

  // One full run from a start pulse driven at the current negedge; returns at the done negedge.
  task automatic run_stream(input logic [14:0] src, input logic [14:0] dst, input bit poke);
    int   cyc;
    int   rd_idx;
    int   wr_idx;
    int   model_corner;
    exp_t e;
    logic [91:0] w;
    sb_q.delete();
    done_seen = 1'b0;
    model_corner = 0;
    run_src = src;
    src_base_i = src;
    dst_base_i = dst;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1; rd_idx = 0; wr_idx = 0;
    while (!done_seen && cyc < TOTAL + 20) begin
      if (cyc == 1) begin
        checks++;
        if (corner_cnt_o !== 11'd0) begin failures++; $display("FAIL corner_clear: got %0d expected 0", corner_cnt_o); end
        checks++;
        if (mem_rd_en_o !== 1'b1) begin failures++; $display("FAIL first_read: rd_en=%0b expected 1", mem_rd_en_o); end
      end
      checks++;
      if (busy_o !== (cyc <= TOTAL + 3)) begin
        failures++; $display("FAIL busy cyc=%0d: got %0b expected %0b", cyc, busy_o, cyc <= TOTAL + 3);
      end
      if (mem_rd_en_o) begin
        checks++;
        if (mem_rd_addr_o !== src + 15'(rd_idx)) begin
          failures++; $display("FAIL rd_addr idx=%0d: got %0h expected %0h", rd_idx, mem_rd_addr_o, src + 15'(rd_idx));
        end
        w = mem_word(src + 15'(rd_idx));
        e.data = r1_of(w);
        e.cyc  = cyc + 3;
        sb_q.push_back(e);
        model_corner = model_corner + corner_pop(w);
        if (model_corner > 2047) model_corner = 2047;
        last_rd_addr = mem_rd_addr_o;
        rd_idx++;
      end
      if (w1_wr_en_o) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL wr_unexpected cyc=%0d: got write expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          if (w1_wr_data_o !== e.data || cyc != e.cyc || w1_wr_addr_o !== dst + 15'(wr_idx)) begin
            failures++;
            $display("FAIL wr idx=%0d: got data=%0h cyc=%0d addr=%0h expected data=%0h cyc=%0d addr=%0h",
                     wr_idx, w1_wr_data_o, cyc, w1_wr_addr_o, e.data, e.cyc, dst + 15'(wr_idx));
          end
        end
        last_wr_addr = w1_wr_addr_o;
        last_wr_data = w1_wr_data_o;
        wr_idx++;
      end
      if (done_o) begin
        checks++;
        if (cyc != TOTAL + 4 || rd_idx != TOTAL || wr_idx != TOTAL || sb_q.size() != 0) begin
          failures++;
          $display("FAIL done_timing: got cyc=%0d reads=%0d writes=%0d pending=%0d expected cyc=%0d reads=%0d writes=%0d pending=0",
                   cyc, rd_idx, wr_idx, sb_q.size(), TOTAL + 4, TOTAL, TOTAL);
        end
        checks++;
        if (corner_cnt_o !== 11'(model_corner)) begin
          failures++; $display("FAIL corner_model: got %0d expected %0d", corner_cnt_o, model_corner);
        end
        done_corner = corner_cnt_o;
        done_seen = 1'b1;
      end
      if (poke && cyc == 50) begin
        src_base_i = 15'h1234; dst_base_i = 15'h0ABC; start_i = 1'b1;
      end else if (poke && done_o) begin
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      if (!done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done at %0d", cyc, TOTAL + 4);
    end
  endtask

  task automatic test_reset;
    rst_b = 1'b0; zeroize = 1'b0; start_i = 1'b0;
    src_base_i = 15'd0; dst_base_i = 15'd0;
    mem_rd_data_i = 92'd0;
    data_mode = 0; corner_mode = 0; run_src = 15'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out_s !== 154'd0) begin failures++; $display("FAIL reset_outputs: got %0h expected 0", all_out_s); end
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out_s !== 154'd0) begin failures++; $display("FAIL idle_outputs: got %0h expected 0", all_out_s); end
  endtask

  task automatic test_fixed_pattern;
    data_mode = 1; corner_mode = 0;
    @(negedge clk);
    run_stream(15'h0100, 15'h0040, 1'b0);
    checks++;
    if (last_rd_addr !== 15'h02FF) begin failures++; $display("FAIL last_rd_addr: got %0h expected 2ff", last_rd_addr); end
    checks++;
    if (last_wr_addr !== 15'h023F) begin failures++; $display("FAIL last_wr_addr: got %0h expected 23f", last_wr_addr); end
    checks++;
    if (last_wr_data !== 16'hF321) begin failures++; $display("FAIL fixed_data: got %0h expected f321", last_wr_data); end
    checks++;
    if (done_corner !== 11'd0) begin failures++; $display("FAIL no_corner: got %0d expected 0", done_corner); end
  endtask

  task automatic test_corner_inject;
    data_mode = 0; corner_mode = 1;
    repeat (2) @(negedge clk);
    run_stream(15'h0100, 15'h0040, 1'b0);
    checks++;
    if (done_corner !== 11'd9) begin failures++; $display("FAIL corner_inject: got %0d expected 9", done_corner); end
    repeat (3) @(negedge clk);
    checks++;
    if (corner_cnt_o !== 11'd9) begin failures++; $display("FAIL corner_hold: got %0d expected 9", corner_cnt_o); end
  endtask

  task automatic test_saturation;
    data_mode = 0; corner_mode = 2;
    repeat (2) @(negedge clk);
    run_stream(15'h0400, 15'h0600, 1'b0);
    checks++;
    if (done_corner !== 11'd2047) begin failures++; $display("FAIL corner_sat: got %0d expected 2047", done_corner); end
  endtask

  task automatic test_start_ignore;
    data_mode = 0; corner_mode = 2;
    repeat (2) @(negedge clk);
    run_stream(15'h0010, 15'h0800, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || mem_rd_en_o !== 1'b0) begin
      failures++; $display("FAIL start_in_done: got busy=%0b rd_en=%0b expected 0 0", busy_o, mem_rd_en_o);
    end
    corner_mode = 0;
    run_stream(15'h0020, 15'h0900, 1'b0);
    checks++;
    if (done_corner !== 11'd0) begin failures++; $display("FAIL corner_after_restart: got %0d expected 0", done_corner); end
  endtask

  task automatic test_wrap;
    data_mode = 0; corner_mode = 0;
    repeat (2) @(negedge clk);
    run_stream(15'h7FF0, 15'h7F00, 1'b0);
    checks++;
    if (last_rd_addr !== 15'h01EF) begin failures++; $display("FAIL wrap_rd: got %0h expected 1ef", last_rd_addr); end
    checks++;
    if (last_wr_addr !== 15'h00FF) begin failures++; $display("FAIL wrap_wr: got %0h expected ff", last_wr_addr); end
  endtask

  task automatic test_zeroize;
    int n;
    data_mode = 0; corner_mode = 2; run_src = 15'h0200;
    repeat (2) @(negedge clk);
    src_base_i = 15'h0200; dst_base_i = 15'h0300; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(mem_rd_en_o && mem_rd_addr_o == 15'h0264) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL zeroize_reach: got no read at 264 expected one"); end
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    checks++;
    if (all_out_s !== 154'd0) begin failures++; $display("FAIL zeroize_outputs: got %0h expected 0", all_out_s); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (w1_wr_en_o || done_o || busy_o || mem_rd_en_o) begin
        failures++; $display("FAIL zeroize_quiet cyc=%0d: got wr=%0b done=%0b busy=%0b rd=%0b expected 0", i, w1_wr_en_o, done_o, busy_o, mem_rd_en_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_flush;
    int n;
    data_mode = 0; corner_mode = 0; run_src = 15'h0000;
    repeat (2) @(negedge clk);
    src_base_i = 15'h0000; dst_base_i = 15'h1000; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (mem_rd_en_o && n < 700) begin @(negedge clk); n++; end
    checks++;
    if (n >= 700 || !busy_o) begin failures++; $display("FAIL flush_reach: got busy=%0b n=%0d expected flush", busy_o, n); end
    rst_b = 1'b0;
    #2;
    checks++;
    if (all_out_s !== 154'd0) begin failures++; $display("FAIL flush_reset_outputs: got %0h expected 0", all_out_s); end
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (w1_wr_en_o || done_o || busy_o || mem_rd_en_o) begin
        failures++; $display("FAIL flush_quiet cyc=%0d: got wr=%0b done=%0b busy=%0b rd=%0b expected 0", i, w1_wr_en_o, done_o, busy_o, mem_rd_en_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    data_mode = 1; corner_mode = 1;
    @(negedge clk);
    run_stream(15'h0300, 15'h0500, 1'b0);
    checks++;
    if (done_corner !== 11'd9) begin failures++; $display("FAIL b2b_first: got %0d expected 9", done_corner); end
    @(negedge clk);
    data_mode = 0;
    run_stream(15'h0A00, 15'h0B00, 1'b0);
    checks++;
    if (last_wr_addr !== 15'h0CFF) begin failures++; $display("FAIL b2b_second: got %0h expected cff", last_wr_addr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fixed_pattern();
    test_corner_inject();
    test_saturation();
    test_start_ignore();
    test_wrap();
    test_zeroize();
    test_reset_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
